// File: rtl/des_feistel_engine.sv
// des_feistel_engine
//
// Iterative DES Feistel round engine. Accepts a post-IP block (L0 in
// [63:32], R0 in [31:0]), runs ROUNDS Feistel rounds with UNROLL rounds
// chained combinationally per clock, and presents the pre-output R||L
// for the FP stage. Subkeys come from an external key-schedule table
// addressed through key_idx; decrypt reverses the subkey order.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    block offered            in_ready   high only in IDLE
//   in_decrypt  0 = encrypt, 1 = decrypt (sampled at accept)
//   in_block    post-IP block {L0, R0}
//   key_idx     per-lane subkey index, lane j at [4j+3:4j]; 0 outside RUN
//   subkey_in   per-lane subkey, lane j at [48j+47:48j], combinational read
//   out_valid   result held in DONE      out_ready  consumer accepts
//   out_block   {R_final, L_final}; 0 outside DONE
//   busy        high in RUN or DONE
module des_feistel_engine #(
    parameter int ROUNDS = 16,
    parameter int UNROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_decrypt,
    input  logic [63:0]           in_block,
    output logic [4*UNROLL-1:0]   key_idx,
    input  logic [48*UNROLL-1:0]  subkey_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_block,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);
    localparam logic [4:0] UNROLL_W = 5'(UNROLL);
    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

    // S1..S8, each box as 64 nibbles: row 0 in the top 64 bits, column 0
    // leftmost within a row, so entry {row, col} sits at nibble 63-entry.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // P permutation in DES numbering (bit 1 = MSB).
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] b);
        logic [5:0]   entry;
        logic [255:0] shifted;
        // Outer bits pick the row, inner four bits pick the column.
        entry   = {b[5], b[0], b[4:1]};
        shifted = SBOX[box] >> {6'd63 - entry, 2'b00};
        return shifted[3:0];
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [33:0] ext;
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] fo;
        // E expansion: each 6-bit group is a window over R with wrap-around,
        // so pad R with its neighbours and take overlapping slices.
        ext = {r[0], r, r[31]};
        x   = '0;
        s   = '0;
        fo  = '0;
        for (int g = 0; g < 8; g++) begin
            x[47-6*g -: 6] = ext[33-4*g -: 6];
        end
        x = x ^ k;
        for (int g = 0; g < 8; g++) begin
            s[31-4*g -: 4] = sbox_lookup(g, x[47-6*g -: 6]);
        end
        for (int i = 0; i < 32; i++) begin
            fo[31-i] = s[32-P_TAB[i]];
        end
        return fo;
    endfunction

    logic [1:0]  state_reg;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [4:0]  rc_reg;
    logic        dec_reg;

    // Lane chain: index 0 is the registered state, index UNROLL is the
    // value written back at the end of the cycle.
    logic [31:0] lane_l [UNROLL+1];
    logic [31:0] lane_r [UNROLL+1];

    assign lane_l[0] = l_reg;
    assign lane_r[0] = r_reg;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : gen_lane
        logic [4:0] rnd_num;
        logic [3:0] idx_sel;

        assign rnd_num = rc_reg + 5'(gi);
        assign idx_sel = 4'(dec_reg ? (LAST_RND - rnd_num) : rnd_num);
        assign key_idx[4*gi +: 4] = (state_reg == ST_RUN) ? idx_sel : 4'd0;

        assign lane_l[gi+1] = lane_r[gi];
        assign lane_r[gi+1] = lane_l[gi] ^ f_func(lane_r[gi], subkey_in[48*gi +: 48]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            l_reg     <= '0;
            r_reg     <= '0;
            rc_reg    <= '0;
            dec_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        l_reg     <= in_block[63:32];
                        r_reg     <= in_block[31:0];
                        dec_reg   <= in_decrypt;
                        rc_reg    <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    l_reg  <= lane_l[UNROLL];
                    r_reg  <= lane_r[UNROLL];
                    rc_reg <= rc_reg + UNROLL_W;
                    if (rc_reg + UNROLL_W == ROUNDS_W) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here means in_ready rises only on the
                    // cycle after the result is taken.
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DONE);
    // After the last round L holds R_final's partner; emitting {R, L}
    // undoes the final swap for the FP stage.
    assign out_block = out_valid ? {r_reg, l_reg} : 64'd0;

endmodule

// File: tb/tb_des_feistel_engine.sv
// Testbench for des_feistel_engine. Three instances: A (ROUNDS=16,
// UNROLL=1), B (ROUNDS=16, UNROLL=4), C (ROUNDS=1, UNROLL=1). Stimulus
// pushes hand-computed expected results into per-instance queues; monitors
// pop and compare whenever the DUT hands a result over.
module tb_des_feistel_engine;

    typedef struct {
        logic [63:0] blk;
        int          acc;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Subkey table for key 133457799BBCDFF1 (K1..K16).
    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    localparam logic [63:0] PT  = 64'hCC00CCFF_F0AAF0AA;
    localparam logic [63:0] CT  = 64'h0A4CD995_43423234;
    localparam logic [63:0] R1X = 64'hEF4A6544_F0AAF0AA;

    // Instance A
    logic         in_valid_a, in_ready_a, in_decrypt_a, out_valid_a, out_ready_a, busy_a;
    logic [63:0]  in_block_a, out_block_a;
    logic [3:0]   key_idx_a;
    logic [47:0]  subkey_a;
    // Instance B
    logic         in_valid_b, in_ready_b, in_decrypt_b, out_valid_b, out_ready_b, busy_b;
    logic [63:0]  in_block_b, out_block_b;
    logic [15:0]  key_idx_b;
    logic [191:0] subkey_b;
    // Instance C
    logic         in_valid_c, in_ready_c, in_decrypt_c, out_valid_c, out_ready_c, busy_c;
    logic [63:0]  in_block_c, out_block_c;
    logic [3:0]   key_idx_c;
    logic [47:0]  subkey_c;

    assign subkey_a = ks[key_idx_a];
    assign subkey_c = ks[key_idx_c];
    for (genvar gi = 0; gi < 4; gi++) begin : gen_kb
        assign subkey_b[48*gi +: 48] = ks[key_idx_b[4*gi +: 4]];
    end

    des_feistel_engine #(.ROUNDS(16), .UNROLL(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_decrypt(in_decrypt_a), .in_block(in_block_a), .key_idx(key_idx_a),
        .subkey_in(subkey_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_block(out_block_a), .busy(busy_a));

    des_feistel_engine #(.ROUNDS(16), .UNROLL(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_decrypt(in_decrypt_b), .in_block(in_block_b), .key_idx(key_idx_b),
        .subkey_in(subkey_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_block(out_block_b), .busy(busy_b));

    des_feistel_engine #(.ROUNDS(1), .UNROLL(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_decrypt(in_decrypt_c), .in_block(in_block_c), .key_idx(key_idx_c),
        .subkey_in(subkey_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_block(out_block_c), .busy(busy_c));

    item_t       q_a[$], q_b[$], q_c[$];
    logic [15:0] kq_a[$], kq_b[$];
    int          acc_a = 0;
    bit          ovp_a = 1'b0, ovp_b = 1'b0, ovp_c = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=missing required=present", name);
    endtask

    // Monitors: compare while the result is presented, pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid_a) begin
            if (q_a.size() == 0) fail_now("a_unexpected_out_valid");
            else begin
                if (!ovp_a) chk("a_latency", 64'(cyc - q_a[0].acc), 64'd16);
                chk("a_out_block", out_block_a, q_a[0].blk);
                chk("a_in_ready_in_done", 64'(in_ready_a), 64'd0);
                if (out_ready_a) begin
                    $display("txn A out_block=%h", out_block_a);
                    void'(q_a.pop_front());
                end
            end
        end
        ovp_a = !rst && out_valid_a;
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b) begin
            if (q_b.size() == 0) fail_now("b_unexpected_out_valid");
            else begin
                if (!ovp_b) chk("b_latency", 64'(cyc - q_b[0].acc), 64'd4);
                chk("b_out_block", out_block_b, q_b[0].blk);
                if (out_ready_b) begin
                    $display("txn B out_block=%h", out_block_b);
                    void'(q_b.pop_front());
                end
            end
        end
        ovp_b = !rst && out_valid_b;
    end

    always @(negedge clk) begin
        if (!rst && out_valid_c) begin
            if (q_c.size() == 0) fail_now("c_unexpected_out_valid");
            else begin
                if (!ovp_c) chk("c_latency", 64'(cyc - q_c[0].acc), 64'd1);
                chk("c_out_block", out_block_c, q_c[0].blk);
                if (out_ready_c) begin
                    $display("txn C out_block=%h", out_block_c);
                    void'(q_c.pop_front());
                end
            end
        end
        ovp_c = !rst && out_valid_c;
    end

    // Record key_idx on every RUN cycle.
    always @(negedge clk) begin
        if (!rst && busy_a && !out_valid_a) kq_a.push_back({12'd0, key_idx_a});
        if (!rst && busy_b && !out_valid_b) kq_b.push_back(key_idx_b);
    end

    always @(posedge clk) begin
        if (!rst && in_valid_a && in_ready_a) acc_a++;
    end

    function automatic int qsize(input int w);
        case (w)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic wait_empty(input int w, input string name);
        int n = 0;
        while (qsize(w) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (qsize(w) != 0) begin
            fail_now(name);
            q_a.delete(); q_b.delete(); q_c.delete();
        end
    endtask

    task automatic issue_a(input logic [63:0] blk, input logic dec, input logic [63:0] exp, input bit hold);
        item_t it;
        int    n = 0;
        while (!in_ready_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready_a) begin
            fail_now("a_in_ready_wait");
            return;
        end
        in_block_a = blk; in_decrypt_a = dec; in_valid_a = 1'b1;
        @(posedge clk); #1;
        it.blk = exp; it.acc = cyc;
        q_a.push_back(it);
        if (!hold) in_valid_a = 1'b0;
        in_block_a   = {$urandom, $urandom};
        in_decrypt_a = ~dec;
    endtask

    task automatic issue_b(input logic [63:0] blk, input logic [63:0] exp);
        item_t it;
        in_block_b = blk; in_decrypt_b = 1'b0; in_valid_b = 1'b1;
        @(posedge clk); #1;
        it.blk = exp; it.acc = cyc;
        q_b.push_back(it);
        in_valid_b = 1'b0;
        in_block_b = {$urandom, $urandom};
    endtask

    task automatic issue_c(input logic [63:0] blk, input logic [63:0] exp);
        item_t it;
        in_block_c = blk; in_decrypt_c = 1'b0; in_valid_c = 1'b1;
        @(posedge clk); #1;
        it.blk = exp; it.acc = cyc;
        q_c.push_back(it);
        in_valid_c = 1'b0;
        in_block_c = {$urandom, $urandom};
    endtask

    task automatic check_keys_a(input bit dec, input string name);
        chk({name, "_count"}, 64'(kq_a.size()), 64'd16);
        for (int i = 0; i < 16 && i < kq_a.size(); i++) begin
            chk(name, 64'(kq_a[i]), dec ? 64'(15 - i) : 64'(i));
        end
    endtask

    initial begin
        int n;
        int acc0;
        logic [15:0] lanes;

        rst = 1'b1;
        in_valid_a = 0; in_decrypt_a = 0; in_block_a = '0; out_ready_a = 1;
        in_valid_b = 0; in_decrypt_b = 0; in_block_b = '0; out_ready_b = 1;
        in_valid_c = 0; in_decrypt_c = 0; in_block_c = '0; out_ready_c = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  64'(in_ready_a),  64'd1);
        chk("reset_out_valid", 64'(out_valid_a), 64'd0);
        chk("reset_busy",      64'(busy_a),      64'd0);
        chk("reset_out_block", out_block_a,      64'd0);
        chk("reset_key_idx_a", 64'(key_idx_a),   64'd0);
        chk("reset_key_idx_b", 64'(key_idx_b),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Encrypt, key_idx 0..15
        kq_a.delete();
        issue_a(PT, 1'b0, CT, 1'b0);
        wait_empty(0, "enc_timeout");
        check_keys_a(1'b0, "enc_key_idx");

        // Decrypt, key_idx 15..0
        kq_a.delete();
        issue_a(CT, 1'b1, PT, 1'b0);
        wait_empty(0, "dec_timeout");
        check_keys_a(1'b1, "dec_key_idx");

        // Single round
        issue_c(PT, R1X);
        wait_empty(2, "r1_timeout");

        // Four rounds per clock
        kq_b.delete();
        issue_b(PT, CT);
        wait_empty(1, "u4_timeout");
        chk("u4_key_count", 64'(kq_b.size()), 64'd4);
        for (int i = 0; i < 4 && i < kq_b.size(); i++) begin
            for (int j = 0; j < 4; j++) lanes[4*j +: 4] = 4'(4*i + j);
            chk("u4_key_lanes", 64'(kq_b[i]), 64'(lanes));
        end

        // Backpressure with in_valid held high
        out_ready_a = 1'b0;
        acc0 = acc_a;
        issue_a(PT, 1'b0, CT, 1'b1);
        n = 0;
        while (!out_valid_a && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid_a) fail_now("bp_out_valid_wait");
        repeat (10) @(posedge clk);
        #1;
        chk("bp_single_accept", 64'(acc_a - acc0), 64'd1);
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after",  64'(in_ready_a),  64'd1);
        chk("bp_out_valid_after", 64'(out_valid_a), 64'd0);
        chk("bp_consumed",        64'(q_a.size()),  64'd0);

        // Reset at round 7
        issue_a(PT, 1'b0, CT, 1'b0);
        n = 0;
        while (key_idx_a != 4'd7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_round7_reached", 64'(key_idx_a), 64'd7);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_in_ready",  64'(in_ready_a),  64'd1);
        chk("rst_mid_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_mid_out_block", out_block_a,      64'd0);
        chk("rst_mid_busy",      64'(busy_a),      64'd0);
        chk("rst_mid_key_idx",   64'(key_idx_a),   64'd0);
        q_a.delete();
        kq_a.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        kq_a.delete();
        issue_a(CT, 1'b1, PT, 1'b0);
        wait_empty(0, "post_rst_timeout");
        check_keys_a(1'b1, "post_rst_key_idx");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
